uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter ClkFrequency, default 50000000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter Baud, default 9600, meaning the serial bit rate in bit/s.
REQ-003 The module SHALL have parameter Oversampling, default 8, meaning ticks per bit; it SHALL be a power of two from 4 to 16.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port rxd, input, 1 bit: the serial line, asynchronous to clk, idle high.
REQ-007 The module SHALL have port data, output, 8 bits: the last good received byte.
REQ-008 The module SHALL have port data_ready, output, 1 bit: one-clk pulse when data is updated.
REQ-009 The module SHALL have port frame_err, output, 1 bit: one-clk pulse on a bad stop bit.
REQ-010 The module SHALL have port idle, output, 1 bit: high while the FSM is in IDLE.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; the synchronized value (rxs) SHALL be the only rxd use.
REQ-012 An internal phase accumulator SHALL generate a one-clk tick at Baud*Oversampling.
- Accumulator width: log2(ClkFrequency/Baud)+8 bits plus carry.
- Tick = carry out.
- Increment rounded so tick-rate error is at most 2%.
REQ-013 The accumulator SHALL be held at zero in IDLE and restart on the start-edge clk, so the first tick lands one tick period after the edge.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP and BREAK, plus PARITY when configured.
REQ-015 IDLE SHALL move to START on the first clk where rxs is 0.
REQ-016 START SHALL sample rxs at tick count Oversampling/2.
- rxs=1: false start, return to IDLE, no output pulse.
- rxs=0: go to DATA, clear the tick counter.
REQ-017 DATA SHALL sample rxs every Oversampling ticks (mid-bit) and shift LSB-first into an 8-bit shift register; after bit 7 it SHALL go to STOP (or PARITY).
REQ-018 STOP SHALL sample rxs at mid-bit, with two outcomes.
- rxs=1: load data from the shift register, pulse data_ready for exactly one clk, go to IDLE.
- rxs=0: pulse frame_err for one clk, leave data unchanged, go to BREAK.
REQ-019 BREAK SHALL stay until rxs is 1, then go to IDLE; a low line SHALL never start a new frame from BREAK.
REQ-020 data_ready and frame_err SHALL never be high in the same clk; data SHALL hold its value between updates.
REQ-021 A new start edge SHALL be accepted on the clk after the STOP sample, with no idle-time gap required.
REQ-022 Latency from the stop-bit mid-point sample to data_ready SHALL be 1 clk.

Reset
REQ-023 Asserting rst SHALL immediately and asynchronously force the following values, including mid-frame, where the partial byte is discarded.
- FSM = IDLE.
- Accumulator, tick counter, bit counter and shift register = 0.
- Synchronizer flops = 1.
- data = 0x00, data_ready = 0, frame_err = 0, idle = 1.
REQ-024 After rst deasserts, a frame already in progress SHALL be received only from its next falling edge.

Configuration
REQ-025 With macro UART_RX_PARITY_EN defined, the module SHALL behave as follows.
- Add a PARITY state between DATA and STOP that samples one even-parity bit at mid-bit.
- Add output parity_err (1 bit, reset 0).
- On a good stop bit with bad parity: pulse parity_err instead of data_ready, leave data unchanged.
REQ-026 Without UART_RX_PARITY_EN, the module SHALL have no PARITY state and no parity_err port, and the frame SHALL be 8N1.

Verification
REQ-027 Defaults, 8N1 frame with byte 0x55 at 5208 clk/bit -> one data_ready pulse, data=0x55, frame_err never high.
REQ-028 Back-to-back frames 0xA3 then 0x00 with zero idle between -> two data_ready pulses, data 0xA3 then 0x00.
REQ-029 rxd low glitch of 1000 clk in IDLE -> return to IDLE, no pulses, data unchanged.
REQ-030 Frame 0x3C with stop bit 0, line held low for 3 bit times, then high, then frame 0x81 -> frame_err pulse once, BREAK held, data=0x81 after the next frame only.
REQ-031 rst asserted mid-bit 4 of frame 0xFF -> outputs at reset values immediately, no pulse for that frame, next frame 0x12 received correctly.
REQ-032 Baud=115200 with frame 0xC5 -> data=0xC5 (tick-rate error at most 2%); with UART_RX_PARITY_EN and parity wrong -> parity_err pulse, no data_ready.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx -- 8-bit asynchronous serial receiver (8N1, optional even parity).
//
// The serial line is brought into the clk domain through a two-flop
// synchronizer. A phase accumulator produces sample ticks at
// Baud*Oversampling. Each bit is sampled once, at its mid-point. The
// accumulator is held at zero while the line is idle. It restarts on the clk
// that detects the start edge, so every sample point is measured from that
// edge.
//
// Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
// between the data bits and the stop bit. This also adds the parity_err
// output.
//
// Parameters
//   ClkFrequency  clk frequency in Hz
//   Baud          serial bit rate in bit/s
//   Oversampling  sample ticks per bit (power of two, 4..16)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   rxd         serial input, asynchronous to clk, idle high
//   data        last correctly received byte
//   data_ready  one-clk pulse when data is updated
//   frame_err   one-clk pulse when the stop bit is sampled low
//   parity_err  (UART_RX_PARITY_EN only) one-clk pulse on a parity mismatch
//   idle        high while the receiver waits for a start edge
module uart_rx #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 9600,
  parameter int Oversampling = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       idle
);

  localparam int AccW = $clog2(ClkFrequency / Baud) + 8;
  localparam int TcW  = $clog2(Oversampling);
  localparam logic [TcW-1:0] HalfLast = TcW'(Oversampling / 2 - 1);
  localparam logic [TcW-1:0] BitLast  = TcW'(Oversampling - 1);

  // The increment is rounded to the nearest integer. The accumulator is at
  // least 8 bits wider than the clk/bit ratio, so the rate error stays far
  // below 1%.
  function automatic logic [AccW-1:0] calc_inc();
    longint num;
    num = (longint'(Baud) * longint'(Oversampling)) << AccW;
    return AccW'((num + longint'(ClkFrequency) / 2) / longint'(ClkFrequency));
  endfunction

  localparam logic [AccW-1:0] Inc = calc_inc();

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_nxt;

  logic            sync_p0;
  logic            rxs;
  logic [AccW-1:0] acc;
  logic [AccW:0]   acc_sum;
  logic            run;
  logic            tick;
  logic            mid;
  logic [TcW-1:0]  tick_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            parity_ok;
  logic            good_c;
  logic            ferr_c;
`ifdef UART_RX_PARITY_EN
  logic            par_bit;
  logic            perr_c;
`endif

  // ---- stage p0/p1: synchronizer (idles high so reset looks like an idle line)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync_p0 <= rxd;
      rxs     <= sync_p0;
    end
  end

  // ---- tick generation
  assign run     = (state != S_IDLE) && (state != S_BREAK);
  assign acc_sum = {1'b0, acc} + {1'b0, Inc};
  assign tick    = run && acc_sum[AccW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (!run) begin
      acc <= '0;
    end else begin
      acc <= acc_sum[AccW-1:0];
    end
  end

  // The sample point is half a bit into the start bit, then one full bit
  // period later for every following bit.
  always_comb begin
    mid = 1'b0;
    if (state == S_START) begin
      mid = tick && (tick_cnt == HalfLast);
    end else if (run) begin
      mid = tick && (tick_cnt == BitLast);
    end
  end

  // ---- FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!rxs) state_nxt = S_START;
      S_START: if (mid) state_nxt = rxs ? S_IDLE : S_DATA;
      S_DATA: begin
        if (mid && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (mid) state_nxt = S_STOP;
`endif
      S_STOP:  if (mid) state_nxt = rxs ? S_IDLE : S_BREAK;
      // A low line here is a break, never a start bit.
      S_BREAK: if (rxs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- FSM: outputs
`ifdef UART_RX_PARITY_EN
  assign parity_ok = ~(^{shreg, par_bit});
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    idle   = (state == S_IDLE);
    good_c = (state == S_STOP) && mid && rxs && parity_ok;
    ferr_c = (state == S_STOP) && mid && !rxs;
`ifdef UART_RX_PARITY_EN
    perr_c = (state == S_STOP) && mid && rxs && !parity_ok;
`endif
  end

  // ---- bit timing and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else if (!run) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (tick) begin
        tick_cnt <= mid ? '0 : tick_cnt + 1'b1;
      end
      if ((state == S_DATA) && mid) begin
        shreg   <= {rxs, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if ((state == S_PARITY) && mid) begin
        par_bit <= rxs;
      end
`endif
    end
  end

  // ---- stage p2: registered results, one clk after the stop-bit sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= 8'h00;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      data_ready <= good_c;
      frame_err  <= ferr_c;
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_c;
`endif
      if (good_c) begin
        data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. Three receivers run side by side:
//   inst 0: default parameters (5208 clk/bit): glitch rejection, frame 0x55
//   inst 1: ClkFrequency=960000 (100 clk/bit): back-to-back, break, reset
//   inst 2: Baud=115200 (434 clk/bit): frame 0xC5 (and a bad-parity frame
//           when UART_RX_PARITY_EN is defined)
// Each stimulus thread queues the outcome a frame must produce: the kind of
// pulse, the byte, and the cycle of the start edge. Every cycle, one compare
// process matches DUT pulses against that queue. The pulse must land in a
// window around the ideal stop-bit mid-point. The process also checks that
// data holds the last good byte.
module tb_uart_rx;

  localparam int K_GOOD = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;
  localparam int K_NONE = 3;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct {
    int         inst;
    int         kind;
    logic [7:0] val;
    longint     edge_cyc;
    int         bitclk;
  } ev_t;

  logic       clk = 1'b0;
  logic       rxd_l  [3];
  logic       rst_l  [3];
  logic [7:0] data_l [3];
  logic       dr_l   [3];
  logic       fe_l   [3];
  logic       pe_l   [3];
  logic       idle_l [3];

  longint     cyc = 0;
  int         checks = 0;
  int         errors = 0;
  ev_t        evq[$];
  logic [7:0] model_data [3];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx u_def (
    .clk(clk), .rst(rst_l[0]), .rxd(rxd_l[0]), .data(data_l[0]),
    .data_ready(dr_l[0]), .frame_err(fe_l[0]),
`ifdef UART_RX_PARITY_EN
    .parity_err(pe_l[0]),
`endif
    .idle(idle_l[0])
  );

  uart_rx #(.ClkFrequency(960000), .Baud(9600), .Oversampling(8)) u_main (
    .clk(clk), .rst(rst_l[1]), .rxd(rxd_l[1]), .data(data_l[1]),
    .data_ready(dr_l[1]), .frame_err(fe_l[1]),
`ifdef UART_RX_PARITY_EN
    .parity_err(pe_l[1]),
`endif
    .idle(idle_l[1])
  );

  uart_rx #(.Baud(115200)) u_fast (
    .clk(clk), .rst(rst_l[2]), .rxd(rxd_l[2]), .data(data_l[2]),
    .data_ready(dr_l[2]), .frame_err(fe_l[2]),
`ifdef UART_RX_PARITY_EN
    .parity_err(pe_l[2]),
`endif
    .idle(idle_l[2])
  );

`ifndef UART_RX_PARITY_EN
  initial begin
    pe_l[0] = 1'b0;
    pe_l[1] = 1'b0;
    pe_l[2] = 1'b0;
  end
`endif

  task automatic chk(input string name, input int inst,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [inst %0d]: got 0x%0h, expected 0x%0h", name, inst, got, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge, never on it.
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input int inst, input logic [7:0] v, input int bitclk,
                            input logic stop_v, input logic par_flip, input int expkind);
    ev_t e;
    if (expkind != K_NONE) begin
      e.inst = inst; e.kind = expkind; e.val = v; e.edge_cyc = cyc; e.bitclk = bitclk;
      evq.push_back(e);
    end
    rxd_l[inst] = 1'b0;
    wait_clks(bitclk);
    for (int b = 0; b < 8; b++) begin
      rxd_l[inst] = v[b];
      wait_clks(bitclk);
    end
`ifdef UART_RX_PARITY_EN
    rxd_l[inst] = (^v) ^ par_flip;
    wait_clks(bitclk);
`else
    if (par_flip) rxd_l[inst] = 1'b1;
`endif
    rxd_l[inst] = stop_v;
    wait_clks(bitclk);
  endtask

  // ---- compare process
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_l[i]) begin
        model_data[i] = 8'h00;
      end else begin
        int     idx;
        int     kind;
        longint ideal;
        longint lo;
        longint hi;
        ev_t    e;
        if (dr_l[i] && fe_l[i]) chk("ready_and_frame_err_together", i, 1, 0);
        if (dr_l[i] || fe_l[i] || pe_l[i]) begin
          kind = dr_l[i] ? K_GOOD : (fe_l[i] ? K_FERR : K_PERR);
          idx = -1;
          foreach (evq[k]) if (idx < 0 && evq[k].inst == i) idx = k;
          if (idx < 0) begin
            chk("unexpected_pulse_kind", i, kind, K_NONE);
          end else begin
            e = evq[idx];
            evq.delete(idx);
            chk("pulse_kind", i, kind, e.kind);
            ideal = e.edge_cyc + longint'(((19 + 2 * PB) * e.bitclk) / 2);
            lo = ideal - e.bitclk / 4;
            hi = ideal + e.bitclk / 4 + 8;
            chk("pulse_time_in_window", i, (cyc >= lo && cyc <= hi) ? 1 : 0, 1);
            if (e.kind == K_GOOD) model_data[i] = e.val;
          end
        end
        chk("data_holds_last_good", i, data_l[i], model_data[i]);
      end
    end
  end

  // ---- stimulus
  initial begin
    for (int i = 0; i < 3; i++) begin
      rxd_l[i] = 1'b1;
      rst_l[i] = 1'b1;
      model_data[i] = 8'h00;
    end
    wait_clks(4);
    for (int i = 0; i < 3; i++) begin
      chk("reset_data", i, data_l[i], 8'h00);
      chk("reset_data_ready", i, dr_l[i], 0);
      chk("reset_frame_err", i, fe_l[i], 0);
      chk("reset_idle", i, idle_l[i], 1);
      rst_l[i] = 1'b0;
    end
    wait_clks(4);

    fork
      // inst 0: default parameters
      begin
        rxd_l[0] = 1'b0;
        wait_clks(500);
        chk("glitch_leaves_idle", 0, idle_l[0], 0);
        wait_clks(500);
        rxd_l[0] = 1'b1;
        wait_clks(3000);
        chk("glitch_back_to_idle", 0, idle_l[0], 1);
        chk("glitch_data_unchanged", 0, data_l[0], 8'h00);
        send_frame(0, 8'h55, 5208, 1'b1, 1'b0, K_GOOD);
        wait_clks(2 * 5208);
        chk("frame_55_data", 0, data_l[0], 8'h55);
      end
      // inst 1: 100 clk/bit
      begin
        send_frame(1, 8'hA3, 100, 1'b1, 1'b0, K_GOOD);
        chk("b2b_first_data", 1, data_l[1], 8'hA3);
        send_frame(1, 8'h00, 100, 1'b1, 1'b0, K_GOOD);
        wait_clks(200);
        chk("b2b_second_data", 1, data_l[1], 8'h00);
        send_frame(1, 8'h3C, 100, 1'b0, 1'b0, K_FERR);
        wait_clks(100);
        chk("break_not_idle", 1, idle_l[1], 0);
        chk("ferr_data_unchanged", 1, data_l[1], 8'h00);
        wait_clks(200);
        rxd_l[1] = 1'b1;
        wait_clks(100);
        chk("break_released_idle", 1, idle_l[1], 1);
        send_frame(1, 8'h81, 100, 1'b1, 1'b0, K_GOOD);
        wait_clks(100);
        chk("after_break_data", 1, data_l[1], 8'h81);
        // frame 0xFF cut by reset in the middle of bit 4
        rxd_l[1] = 1'b0;
        wait_clks(100);
        rxd_l[1] = 1'b1;
        wait_clks(450);
        chk("mid_frame_not_idle", 1, idle_l[1], 0);
        rst_l[1] = 1'b1;
        #1;
        chk("async_reset_data", 1, data_l[1], 8'h00);
        chk("async_reset_idle", 1, idle_l[1], 1);
        chk("async_reset_ready", 1, dr_l[1], 0);
        chk("async_reset_ferr", 1, fe_l[1], 0);
        wait_clks(3);
        rst_l[1] = 1'b0;
        wait_clks(550);
        send_frame(1, 8'h12, 100, 1'b1, 1'b0, K_GOOD);
        wait_clks(200);
        chk("after_reset_data", 1, data_l[1], 8'h12);
      end
      // inst 2: 115200 baud
      begin
        send_frame(2, 8'hC5, 434, 1'b1, 1'b0, K_GOOD);
        wait_clks(434);
`ifdef UART_RX_PARITY_EN
        send_frame(2, 8'h5A, 434, 1'b1, 1'b1, K_PERR);
        wait_clks(434);
`endif
        wait_clks(434);
        chk("fast_data", 2, data_l[2], 8'hC5);
      end
    join

    for (int i = 0; i < 3; i++) begin
      int pend;
      pend = 0;
      foreach (evq[k]) if (evq[k].inst == i) pend++;
      chk("no_missing_pulse", i, pend, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
